div_share_ctrl: RTL and testbench
=================================

# div_share_ctrl

Controller that shares the single iterative divider between the two EX pipes. It captures divide/modulo requests from pipe0 and pipe1, serialises them onto the divider in program order (pipe0 first), and latches the results. It stalls the EX2 stage until every requested operation in the current issue pair is complete, then presents the results to the EX2→WB register with a one-cycle acknowledge. Pipeline flushes abort the sequence.

## Interface
- `ZERO_Q`, default 32'hFFFF_FFFF: quotient returned for a zero divisor. The remainder for a zero divisor is the dividend.
- `clk` in 1: clock.
- `rst` in 1: synchronous reset, active-high.
- `flush` in 1: pipeline flush (exception or branch). Highest priority.
- `req0` / `req1` in 1: pipe has a div/mod op. Held until `div_ack` or `flush`.
- `signed0` / `signed1` in 1: 1 = signed op (div.w / mod.w), 0 = unsigned.
- `rem0` / `rem1` in 1: 1 = remainder wanted (mod), 0 = quotient.
- `a0`, `b0`, `a1`, `b1` in 32: dividend and divisor for each pipe.
- `rd0` / `rd1` in 5: destination register for each pipe.
- `div_start` out 1: one-cycle start pulse to the divider.
- `div_signed` out 1: signedness of the current op.
- `div_dividend` / `div_divisor` out 32: operands of the current op, held stable while running.
- `div_abort` out 1: one-cycle pulse that kills the in-flight divide.
- `div_done` in 1: one-cycle pulse from the divider, N ≥ 1 cycles after `div_start`.
- `div_quotient` / `div_remainder` in 32: divider results, valid while `div_done` is high.
- `div_stall` out 1: holds EX2 (feeds `ex2_allowin`).
- `div_ack` out 1: one-cycle pulse; results valid and EX2 advances this cycle.
- `res0` / `res1` out 32: selected result per pipe.
- `res0_valid` / `res1_valid` out 1: the pipe had a request in this pair.
- `res0_rd` / `res1_rd` out 5: latched destination per pipe.

## Operation
- FSM states: IDLE, RUN0, RUN1, DONE.
- Internal flag `started` marks that the current RUN state has already issued its start.
- **IDLE.** If `req0|req1` and not `flush`:
  - latch all operands, ops and rds into request registers;
  - set `pend0 = req0`, `pend1 = req1`;
  - go to RUN0 if `req0`, else RUN1.
- **RUNx, first cycle (`started = 0`):**
  - divisor == 0: write `ZERO_Q` or the dividend into `resx` immediately. No `div_start` is issued.
  - otherwise: `div_start = 1`, `started <= 1`.
- **RUNx, waiting:** on `div_done`, latch `rem ? div_remainder : div_quotient` into `resx` and clear `started`.
- **Leaving RUN0:** go to RUN1 if `pend1`, else DONE.
- **Leaving RUN1:** go to DONE.
- **DONE:** `div_ack = 1` and `resX_valid = pendX` for one cycle, then IDLE. A new request can be sampled in the following IDLE cycle.
- **Stall:**
  - `div_stall = (req0|req1) & (state != DONE)`.
  - It is therefore 1 in IDLE when a request is present, and 0 in the ack cycle.
- **Operand drive:** `div_signed`, `div_dividend` and `div_divisor` are driven from the registers of the pipe being served. They are 0 in IDLE and DONE.
- **Flush:**
  - A flush in any state forces IDLE and clears `pend*` and `started`.
  - If `started = 1`, `div_abort` pulses in that same cycle.
  - A `div_done` arriving in the flush cycle is discarded.
  - A flush in DONE suppresses `div_ack`, because flush has priority.
- **Reset:** state IDLE. Every output is 0, including `res*`, `res*_valid`, `res*_rd`, `div_*` and `div_stall`. `div_abort` is not pulsed on reset.

## Timing
- All state and result registers update on the `clk` rising edge. `div_start`, `div_abort`, `div_stall` and `div_ack` are combinational from state and inputs.
- Single op with divider latency N:
  - cycle 0: IDLE samples the request.
  - cycle 1: `div_start`.
  - cycle 1+N: `div_done`.
  - cycle 2+N: `div_ack`.
- Both pipes: `div_ack` at cycle 3 + 2N.
- Zero divisor: the RUN state lasts one cycle. A single op acks at cycle 2.
- The `res*` registers hold their values after ack until the next pair completes.

## Test plan
- Reset, then `req0` signed with a0 = -7, b0 = 2, rem0 = 0, rd0 = 5, divider N = 4:
  - `div_start` in cycle 1;
  - `div_ack` in cycle 6 with `res0 = 32'hFFFF_FFFD` (-3), `res0_rd = 5`, `res0_valid = 1`, `res1_valid = 0`;
  - `div_stall` is 1 in cycles 0–5.
- `req0` and `req1` together (unsigned 100/7 quotient; signed -7 mod 2), N = 4:
  - two `div_start` pulses, at cycle 1 and cycle 6;
  - `div_ack` at cycle 11 with `res0 = 14`, `res1 = 32'hFFFF_FFFF` (-1).
- `req1` only, b1 = 0, a1 = 9, rem1 = 1:
  - no `div_start`;
  - `div_ack` at cycle 2 with `res1 = 9`.
- `req0` and `req1`, flush asserted 2 cycles after the first `div_start`:
  - `div_abort` pulses in that cycle and the state returns to IDLE;
  - no `div_ack` follows;
  - a later `div_done` is ignored.
- `rst` asserted during RUN1:
  - the next cycle shows IDLE with all outputs 0;
  - a fresh `req0` then completes normally.
- Back-to-back pairs, with new requests presented in the cycle after `div_ack`:
  - the second pair is sampled without loss;
  - `res*` keep the first pair's values until the second `div_ack`.

Source files
------------

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
// Shares one iterative divider between the two EX pipes. It captures the div/mod
// requests of an issue pair and runs them on the divider one at a time, pipe0
// first. It stalls EX2 until every requested operation has finished, then
// acknowledges for one cycle with the per-pipe results.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush                     pipeline flush; aborts the sequence (highest priority)
//   req*/signed*/rem*         per-pipe request, signedness, remainder-select
//   a*/b*/rd*                 per-pipe dividend, divisor, destination register
//   div_start/div_abort       one-cycle start / kill pulses to the divider
//   div_signed/div_dividend/div_divisor  operands of the op being served
//   div_done/div_quotient/div_remainder  divider completion and results
//   div_stall                 holds EX2 while the pair is incomplete
//   div_ack                   one-cycle pulse: results valid, EX2 advances
//   res*/res*_valid/res*_rd   per-pipe result, request flag, destination
module div_share_ctrl #(
  parameter logic [31:0] ZERO_Q = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req0,
  input  logic        req1,
  input  logic        signed0,
  input  logic        signed1,
  input  logic        rem0,
  input  logic        rem1,
  input  logic [31:0] a0,
  input  logic [31:0] b0,
  input  logic [31:0] a1,
  input  logic [31:0] b1,
  input  logic [4:0]  rd0,
  input  logic [4:0]  rd1,
  output logic        div_start,
  output logic        div_signed,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  output logic        div_abort,
  input  logic        div_done,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  output logic        div_stall,
  output logic        div_ack,
  output logic [31:0] res0,
  output logic [31:0] res1,
  output logic        res0_valid,
  output logic        res1_valid,
  output logic [4:0]  res0_rd,
  output logic [4:0]  res1_rd
);

  typedef enum logic [1:0] {IDLE, RUN0, RUN1, DONE} state_t;

  state_t      state, state_nxt;
  logic        pend0, pend1, started;
  logic        sg0_q, sg1_q, rm0_q, rm1_q;
  logic [31:0] a0_q, b0_q, a1_q, b1_q;

  logic        cur_sg, cur_rm, op_end;
  logic [31:0] cur_a, cur_b, op_result;

  // Operands of the pipe currently being served.
  always_comb begin
    cur_sg = (state == RUN1) ? sg1_q : sg0_q;
    cur_rm = (state == RUN1) ? rm1_q : rm0_q;
    cur_a  = (state == RUN1) ? a1_q  : a0_q;
    cur_b  = (state == RUN1) ? b1_q  : b0_q;
    // A zero divisor never reaches the divider, so an unstarted op resolves locally.
    if (started) op_result = cur_rm ? div_remainder : div_quotient;
    else         op_result = cur_rm ? cur_a : ZERO_Q;
  end

  always_comb begin
    state_nxt    = state;
    div_start    = 1'b0;
    div_signed   = 1'b0;
    div_dividend = '0;
    div_divisor  = '0;
    div_ack      = 1'b0;
    res0_valid   = 1'b0;
    res1_valid   = 1'b0;
    op_end       = 1'b0;
    div_abort    = flush & started;
    div_stall    = (req0 | req1) & (state != DONE);
    case (state)
      IDLE: begin
        if ((req0 | req1) && !flush) state_nxt = req0 ? RUN0 : RUN1;
      end
      RUN0, RUN1: begin
        div_signed   = cur_sg;
        div_dividend = cur_a;
        div_divisor  = cur_b;
        if (!flush) begin
          if (!started) begin
            if (cur_b == '0) op_end = 1'b1;
            else             div_start = 1'b1;
          end else if (div_done) begin
            op_end = 1'b1;
          end
          if (op_end) state_nxt = (state == RUN0 && pend1) ? RUN1 : DONE;
        end
      end
      DONE: begin
        if (!flush) begin
          div_ack    = 1'b1;
          res0_valid = pend0;
          res1_valid = pend1;
        end
        state_nxt = IDLE;
      end
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      started <= 1'b0;
      sg0_q   <= 1'b0;
      sg1_q   <= 1'b0;
      rm0_q   <= 1'b0;
      rm1_q   <= 1'b0;
      a0_q    <= '0;
      b0_q    <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      res0    <= '0;
      res1    <= '0;
      res0_rd <= '0;
      res1_rd <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        pend0   <= 1'b0;
        pend1   <= 1'b0;
        started <= 1'b0;
      end else begin
        if (state == IDLE && (req0 | req1)) begin
          pend0   <= req0;
          pend1   <= req1;
          sg0_q   <= signed0;
          sg1_q   <= signed1;
          rm0_q   <= rem0;
          rm1_q   <= rem1;
          a0_q    <= a0;
          b0_q    <= b0;
          a1_q    <= a1;
          b1_q    <= b1;
          res0_rd <= rd0;
          res1_rd <= rd1;
        end
        if (div_start) started <= 1'b1;
        if (op_end) begin
          started <= 1'b0;
          if (state == RUN0) res0 <= op_result;
          else               res1 <= op_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
// Testbench for div_share_ctrl: directed scenarios followed by randomized
// back-to-back pairs, with a behavioural divider and a reference result model.
module tb_div_share_ctrl;

  localparam logic [31:0] ZQ = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        signed0 = 1'b0, signed1 = 1'b0;
  logic        rem0 = 1'b0, rem1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [4:0]  rd0 = '0, rd1 = '0;
  logic        div_start, div_signed, div_abort, div_stall, div_ack;
  logic [31:0] div_dividend, div_divisor;
  logic        div_done = 1'b0;
  logic [31:0] div_quotient = '0, div_remainder = '0;
  logic [31:0] res0, res1;
  logic        res0_valid, res1_valid;
  logic [4:0]  res0_rd, res1_rd;

  div_share_ctrl #(.ZERO_Q(ZQ)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0(req0), .req1(req1), .signed0(signed0), .signed1(signed1),
    .rem0(rem0), .rem1(rem1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .rd0(rd0), .rd1(rd1),
    .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_abort(div_abort), .div_done(div_done),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_stall(div_stall), .div_ack(div_ack),
    .res0(res0), .res1(res1), .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res0_rd(res0_rd), .res1_rd(res1_rd)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat = 4;
  bit ignore_abort = 1'b0;
  logic [31:0] prev0 = '0, prev1 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural divider: done pulses 'lat' cycles after the start cycle.
  bit busy = 1'b0;
  int cnt = 0;
  logic [31:0] dq, dr;
  longint sa, sb;
  always @(negedge clk) begin
    div_done = 1'b0;
    if (busy) begin
      cnt--;
      if (cnt == 0) begin
        div_done = 1'b1;
        div_quotient = dq;
        div_remainder = dr;
        busy = 1'b0;
      end
    end
    if (div_abort && !ignore_abort) busy = 1'b0;
    if (div_start) begin
      busy = 1'b1;
      cnt = lat;
      if (div_divisor == 0) begin
        dq = '1; dr = div_dividend;
      end else if (div_signed) begin
        sa = longint'($signed(div_dividend));
        sb = longint'($signed(div_divisor));
        dq = 32'(sa / sb);
        dr = 32'(sa % sb);
      end else begin
        dq = div_dividend / div_divisor;
        dr = div_dividend % div_divisor;
      end
    end
  end

  // Reference: truncating division, remainder = a - q*b, zero-divisor rule.
  function automatic logic [31:0] ref_res(input logic sg, input logic rm,
                                          input logic [31:0] a, input logic [31:0] b);
    longint x, y, q;
    if (b == 0) return rm ? a : ZQ;
    if (sg) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'd0, a});
      y = longint'({32'd0, b});
    end
    q = x / y;
    return rm ? 32'(x - q * y) : 32'(q);
  endfunction

  task automatic set_req(input logic r0, input logic s0, input logic m0, input logic [31:0] av0,
                         input logic [31:0] bv0, input logic [4:0] d0,
                         input logic r1, input logic s1, input logic m1, input logic [31:0] av1,
                         input logic [31:0] bv1, input logic [4:0] d1);
    req0 = r0; signed0 = s0; rem0 = m0; a0 = av0; b0 = bv0; rd0 = d0;
    req1 = r1; signed1 = s1; rem1 = m1; a1 = av1; b1 = bv1; rd1 = d1;
  endtask

  // Called at posedge+1 with the pair on the inputs and the DUT idle. Returns at
  // posedge+1 of the cycle after the ack, inputs untouched.
  task automatic run_pair(input string tag);
    int t, end0, end1, exp_ack, cyc, bad_stall, bad_hold;
    int exp_st[$];
    int got_st[$];
    logic [31:0] e0, e1, h0, h1;
    bit got_ack;
    t = 1; end0 = 0; end1 = 0;
    if (req0) begin
      if (b0 != 0) exp_st.push_back(t);
      t += (b0 == 0) ? 1 : lat + 1;
      end0 = t;
    end
    if (req1) begin
      if (b1 != 0) exp_st.push_back(t);
      t += (b1 == 0) ? 1 : lat + 1;
      end1 = t;
    end
    exp_ack = t;
    e0 = req0 ? ref_res(signed0, rem0, a0, b0) : prev0;
    e1 = req1 ? ref_res(signed1, rem1, a1, b1) : prev1;
    cyc = 0; got_ack = 1'b0; bad_stall = 0; bad_hold = 0;
    while (!got_ack && cyc < 200) begin
      @(negedge clk);
      if (div_start) got_st.push_back(cyc);
      if (div_stall !== (cyc != exp_ack)) bad_stall++;
      h0 = (req0 && cyc >= end0) ? e0 : prev0;
      h1 = (req1 && cyc >= end1) ? e1 : prev1;
      if (res0 !== h0 || res1 !== h1) bad_hold++;
      if (div_ack) begin
        got_ack = 1'b1;
        chk({tag, ".ack_cycle"}, cyc, exp_ack);
        chk({tag, ".res0"}, res0, e0);
        chk({tag, ".res1"}, res1, e1);
        chk({tag, ".res0_valid"}, res0_valid, req0);
        chk({tag, ".res1_valid"}, res1_valid, req1);
        chk({tag, ".res0_rd"}, res0_rd, rd0);
        chk({tag, ".res1_rd"}, res1_rd, rd1);
        chk({tag, ".n_start"}, got_st.size(), exp_st.size());
        for (int i = 0; i < exp_st.size() && i < got_st.size(); i++)
          chk({tag, ".start_cycle"}, got_st[i], exp_st[i]);
        chk({tag, ".stall_bad_cycles"}, bad_stall, 0);
        chk({tag, ".res_hold_bad_cycles"}, bad_hold, 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!got_ack) chk({tag, ".ack_timeout"}, 32'd0, 32'd1);
    prev0 = e0;
    prev1 = e1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic r0, r1;
    logic [31:0] av, bv;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.res0", res0, 0);
    chk("rst.res1", res1, 0);
    chk("rst.ctl", {div_start, div_signed, div_abort, div_stall, div_ack,
                    res0_valid, res1_valid}, 0);
    chk("rst.rd_ops", {res0_rd, res1_rd, div_dividend[10:0], div_divisor[10:0]}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single signed quotient, -7/2 -> -3
    lat = 4;
    set_req(1, 1, 0, -32'sd7, 32'd2, 5'd5, 0, 0, 0, 0, 0, 0);
    run_pair("single");
    chk("single.res0_val", res0, 32'hFFFF_FFFD);
    // Back-to-back pair: 100/7 unsigned and -7 mod 2 signed
    set_req(1, 0, 0, 32'd100, 32'd7, 5'd7, 1, 1, 1, -32'sd7, 32'd2, 5'd9);
    run_pair("pair");
    // pipe1 only, zero divisor, remainder -> dividend
    set_req(0, 0, 0, 0, 0, 0, 1, 0, 1, 32'd9, 32'd0, 5'd3);
    run_pair("zero");
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle.valid", {res0_valid, res1_valid, div_ack}, 0);
    @(posedge clk); #1;

    // Flush two cycles after the first start; divider keeps running and its done is ignored
    ignore_abort = 1'b1;
    set_req(1, 0, 0, 32'd50, 32'd3, 5'd1, 1, 0, 0, 32'd60, 32'd4, 5'd2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 1) chk("flush.start", div_start, 1);
      if (c == 2) chk("flush.no_early_abort", div_abort, 0);
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush.abort", div_abort, 1);
    chk("flush.stall", div_stall, 1);
    @(posedge clk); #1;
    flush = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("flush.idle_ops", div_dividend | div_divisor, 0);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (div_ack || div_start || div_abort || div_stall || res0 !== prev0 || res1 !== prev1) bad++;
      @(negedge clk);
    end
    chk("flush.quiet_after", bad, 0);
    ignore_abort = 1'b0;
    @(posedge clk); #1;

    // Reset during RUN1
    lat = 2;
    set_req(1, 0, 0, 32'd20, 32'd6, 5'd4, 1, 0, 1, 32'd30, 32'd7, 5'd6);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        chk("rst_run1.start", div_start, 1);
        chk("rst_run1.dividend", div_dividend, 32'd30);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_run1.res", res0 | res1, 0);
    chk("rst_run1.ctl", {div_start, div_signed, div_abort, div_stall, div_ack,
                         res0_valid, res1_valid, res0_rd, res1_rd}, 0);
    chk("rst_run1.ops", div_dividend | div_divisor, 0);
    prev0 = '0; prev1 = '0;
    @(posedge clk); #1;
    set_req(1, 0, 1, 32'd17, 32'd5, 5'd12, 0, 0, 0, 0, 0, 0);
    run_pair("after_rst");

    // Randomized back-to-back pairs
    for (int n = 0; n < 30; n++) begin
      lat = int'($urandom_range(1, 5));
      r0 = 1'($urandom_range(0, 1));
      r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int p = 0; p < 2; p++) begin
        case ($urandom_range(0, 4))
          0: begin av = $urandom; bv = 32'd0; end
          1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
          2: begin av = $urandom_range(0, 200) - 100; bv = $urandom_range(1, 9); end
          3: begin av = $urandom; bv = -$urandom_range(1, 9); end
          default: begin av = $urandom; bv = $urandom; end
        endcase
        if (p == 0) begin
          req0 = r0; signed0 = 1'($urandom); rem0 = 1'($urandom);
          a0 = av; b0 = bv; rd0 = 5'($urandom);
        end else begin
          req1 = r1; signed1 = 1'($urandom); rem1 = 1'($urandom);
          a1 = av; b1 = bv; rd1 = 5'($urandom);
        end
      end
      run_pair($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
